// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - MIPS IF stage: PC owner, single-outstanding imem fetch, skid-buffered output to IF/ID
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    output logic [31:0] o_ID_data_instruction,
    output logic [31:0] o_EX_data_PCNext
);

    // S_REQ: issuing a fetch; S_WAIT: fetch outstanding; S_FULL: skid holds a word;
    // S_DRAIN: waiting to throw away the response of a fetch made stale by a redirect
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc;            // address of the next fetch to issue
    logic [31:0] req_pc;        // address of the fetch currently outstanding
    logic [31:0] skid_data;
    logic [31:0] skid_pcnext;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pcnext;

    logic        slot_free;
    logic        fetch_accept;
    logic        load_mem;
    logic        park_skid;
    logic        load_skid;
    logic        out_load;

    // Decode of the datapath events this cycle (redirect overrides all of them)
    always_comb begin
        slot_free    = !out_valid || !i_stall;
        fetch_accept = (state == S_REQ) && i_imem_ready;
        load_mem     = (state == S_WAIT) && i_imem_rvalid && slot_free;
        park_skid    = (state == S_WAIT) && i_imem_rvalid && !slot_free;
        load_skid    = (state == S_FULL) && !i_stall;
        out_load     = load_mem || load_skid;
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a redirect only enters S_DRAIN when a fetch is still in flight after the edge
    always_comb begin
        state_nxt = state;
        if (i_redirect) begin
            case (state)
                S_REQ:   state_nxt = i_imem_ready  ? S_DRAIN : S_REQ;
                S_WAIT:  state_nxt = i_imem_rvalid ? S_REQ   : S_DRAIN;
                S_FULL:  state_nxt = S_REQ;
                S_DRAIN: state_nxt = i_imem_rvalid ? S_REQ   : S_DRAIN;
                default: state_nxt = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ:   if (i_imem_ready)  state_nxt = S_WAIT;
                S_WAIT:  if (i_imem_rvalid) state_nxt = slot_free ? S_REQ : S_FULL;
                S_FULL:  if (!i_stall)      state_nxt = S_REQ;
                S_DRAIN: if (i_imem_rvalid) state_nxt = S_REQ;
                default: state_nxt = S_REQ;
            endcase
        end
    end

    // Memory-side outputs; the request is held low for as long as reset is asserted
    always_comb begin
        o_imem_req  = nrst && (state == S_REQ);
        o_imem_addr = pc;
    end

    // PC and outstanding-fetch address tracking
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pc     <= RESET_PC & WORD_MASK;
            req_pc <= RESET_PC & WORD_MASK;
        end else if (i_redirect) begin
            pc <= i_redirect_target & WORD_MASK;
        end else if (fetch_accept) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
        end
    end

    // Skid buffer: catches a response that arrives while IF/ID is stalled and full
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            skid_data   <= 32'h0;
            skid_pcnext <= 32'h0;
        end else if (i_redirect || load_skid) begin
            skid_data   <= 32'h0;
            skid_pcnext <= 32'h0;
        end else if (park_skid) begin
            skid_data   <= i_imem_rdata;
            skid_pcnext <= req_pc + 32'd4;
        end
    end

    // IF/ID output slot: load new word, drop a consumed one, or hold under stall
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_valid  <= 1'b0;
            out_instr  <= 32'h0;
            out_pcnext <= 32'h0;
        end else if (i_redirect) begin
            out_valid <= 1'b0;
            out_instr <= 32'h0;
        end else if (load_mem) begin
            out_valid  <= 1'b1;
            out_instr  <= i_imem_rdata;
            out_pcnext <= req_pc + 32'd4;
        end else if (load_skid) begin
            out_valid  <= 1'b1;
            out_instr  <= skid_data;
            out_pcnext <= skid_pcnext;
        end else if (!i_stall && !out_load) begin
            out_valid <= 1'b0;
            out_instr <= 32'h0;
        end
    end

    // Presented instruction is a NOP whenever the slot is empty
    always_comb begin
        o_valid               = out_valid;
        o_ID_data_instruction = out_valid ? out_instr : 32'h0;
        o_EX_data_PCNext      = out_pcnext;
    end

endmodule
